// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON rate-block sequencer.
package ascon_pkg;

  localparam int          ASCON_RATE_BYTES = 8;
  localparam logic [63:0] ASCON_PAD_WORD   = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    PAD  = 2'd3
  } ascon_seq_state_e;

endpackage

// File: rtl/ascon_pad_unit.sv
// Combinational 10* padding of a 64-bit rate block holding `len` message bytes.
// Lengths above 8 are treated as a full block.
module ascon_pad_unit
  import ascon_pkg::*;
(
  input  logic [63:0] din,
  input  logic [3:0]  len,
  output logic [63:0] dout
);

  logic [3:0]  w_len;
  logic [6:0]  w_shamt;
  logic [63:0] w_keep;
  logic [63:0] w_marker;

  // Keep the leading message bytes and place the 0x80 marker right after them.
  always_comb begin
    w_len    = len;
    w_shamt  = 7'd0;
    w_keep   = 64'h0;
    w_marker = 64'h0;
    if (len > 4'd8) begin
      w_len = 4'd8;
    end else begin
      w_len = len;
    end
    w_shamt = {w_len, 3'b000};
    if (w_len == 4'd8) begin
      w_keep   = 64'hFFFF_FFFF_FFFF_FFFF;
      w_marker = 64'h0;
    end else begin
      w_keep   = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_shamt);
      w_marker = ASCON_PAD_WORD >> w_shamt;
    end
    dout = (din & w_keep) | w_marker;
  end

endmodule

// File: rtl/ascon_block_sequencer.sv
// Packs a byte stream into 64-bit ASCON rate blocks with 10* padding on the
// final block; one block is handed to the absorb controller per handshake.
module ascon_block_sequencer
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        start_empty,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] blk_data,
  output logic [3:0]  blk_len,
  output logic        blk_last,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        busy
);

  ascon_seq_state_e r_state;
  logic [3:0]       r_cnt;
  logic [63:0]      r_buf;
  logic             r_final;
  logic             r_need_pad;
  logic             r_in_ready;
  logic             r_blk_valid;
  logic             r_blk_last;
  logic             r_busy;

  logic [3:0]       w_cnt_nxt;
  logic             w_block_full;
  logic [63:0]      w_lane;
  logic [3:0]       w_pad_len;
  logic [63:0]      w_pad_dout;

  assign w_cnt_nxt    = r_cnt + 4'd1;
  assign w_block_full = (w_cnt_nxt == 4'(ASCON_RATE_BYTES));
  // In FILL r_cnt is 0..7, so its low 3 bits select the lane.
  assign w_lane       = {56'h0, in_data} << {(3'd7 - r_cnt[2:0]), 3'b000};

  // The padding unit sees the buffer in EMIT and an empty block in PAD.
  always_comb begin
    w_pad_len = r_cnt;
    if (r_state == PAD) begin
      w_pad_len = 4'd0;
    end else begin
      w_pad_len = r_cnt;
    end
  end

  ascon_pad_unit u_pad (
    .din  (r_buf),
    .len  (w_pad_len),
    .dout (w_pad_dout)
  );

  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;
  assign busy      = r_busy;
  assign blk_data  = r_blk_valid ? w_pad_dout : 64'h0;
  assign blk_len   = (r_state == EMIT) ? r_cnt : 4'd0;

  // Sequencer FSM with registered handshake and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_buf       <= 64'h0;
      r_final     <= 1'b0;
      r_need_pad  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt      <= 4'd0;
            r_buf      <= 64'h0;
            r_final    <= 1'b0;
            r_need_pad <= 1'b0;
            r_busy     <= 1'b1;
            if (start_empty) begin
              r_state     <= PAD;
              r_blk_valid <= 1'b1;
              r_blk_last  <= 1'b1;
            end else begin
              r_state    <= FILL;
              r_in_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (in_valid) begin
            r_buf <= r_buf | w_lane;
            r_cnt <= w_cnt_nxt;
            if (in_last) begin
              r_final     <= 1'b1;
              r_need_pad  <= w_block_full;
              r_state     <= EMIT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_blk_last  <= ~w_block_full;
            end else if (w_block_full) begin
              r_final     <= 1'b0;
              r_state     <= EMIT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_blk_last  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (r_need_pad) begin
              r_state    <= PAD;
              r_blk_last <= 1'b1;
            end else if (r_final) begin
              r_state     <= IDLE;
              r_final     <= 1'b0;
              r_blk_valid <= 1'b0;
              r_blk_last  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_state     <= FILL;
              r_buf       <= 64'h0;
              r_cnt       <= 4'd0;
              r_blk_valid <= 1'b0;
              r_blk_last  <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
        PAD: begin
          if (blk_ready) begin
            r_state     <= IDLE;
            r_final     <= 1'b0;
            r_need_pad  <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= 4'd0;
          r_buf       <= 64'h0;
          r_final     <= 1'b0;
          r_need_pad  <= 1'b0;
          r_in_ready  <= 1'b0;
          r_blk_valid <= 1'b0;
          r_blk_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Scoreboard bench: a byte-level message model predicts the block sequence,
// and an independent monitor compares every consumed block.
module tb_ascon_block_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start, start_empty;
  logic [7:0]  in_data;
  logic        in_valid, in_last;
  logic        in_ready;
  logic [63:0] blk_data;
  logic [3:0]  blk_len;
  logic        blk_last, blk_valid;
  logic        blk_ready;
  logic        busy;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  len;
    logic        last;
  } blk_t;

  blk_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        rdy_auto  = 1'b1;
  logic        rdy_force = 1'b0;
  logic [7:0]  msg[$];

  ascon_block_sequencer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .start_empty(start_empty),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_len(blk_len), .blk_last(blk_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: split the message into 8-byte blocks and apply 10* padding.
  task automatic push_expected(input logic [7:0] m[$]);
    int L = m.size();
    int nfull = L / 8;
    int r = L % 8;
    blk_t b;
    logic [7:0] tmp [8];
    for (int i = 0; i < nfull; i++) begin
      b.data = 64'h0;
      for (int k = 0; k < 8; k++) b.data = (b.data << 8) | {56'h0, m[8*i+k]};
      b.len = 4'd8;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    if (r == 0) begin
      b.data = 64'h8000_0000_0000_0000;
      b.len = 4'd0;
      b.last = 1'b1;
    end else begin
      for (int k = 0; k < 8; k++) tmp[k] = 8'h00;
      for (int k = 0; k < r; k++) tmp[k] = m[8*nfull+k];
      tmp[r] = 8'h80;
      b.data = 64'h0;
      for (int k = 0; k < 8; k++) b.data = (b.data << 8) | {56'h0, tmp[k]};
      b.len = 4'(r);
      b.last = 1'b1;
    end
    exp_q.push_back(b);
  endtask

  // Consumer side: blk_ready is randomised or forced, updated away from the edge.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      blk_ready = rdy_auto ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: every accepted block is popped from the scoreboard and compared.
  always @(negedge clk) begin
    blk_t e;
    if (n_rst && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_block: got %h len %0d, expected no block", blk_data, blk_len);
      end else begin
        e = exp_q.pop_front();
        check("blk_data", blk_data, e.data);
        check("blk_len", {60'h0, blk_len}, {60'h0, e.len});
        check("blk_last", {63'h0, blk_last}, {63'h0, e.last});
      end
    end
  end

  task automatic start_msg(input logic empty);
    start = 1'b1;
    start_empty = empty;
    @(posedge clk); #1;
    start = 1'b0;
    start_empty = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] d, input logic last, input logic gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_data = d;
    in_valid = 1'b1;
    in_last = last;
    while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 2000) begin @(posedge clk); #1; t++; end
    check({name, "_idle_busy"}, {63'h0, busy}, 64'h0);
    check({name, "_idle_pending"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic send_msg(input string name, input logic [7:0] m[$]);
    push_expected(m);
    if (m.size() == 0) begin
      start_msg(1'b1);
      check({name, "_empty_valid"}, {63'h0, blk_valid}, 64'h1);
    end else begin
      start_msg(1'b0);
      for (int i = 0; i < m.size(); i++) feed_byte(m[i], i == m.size() - 1, 1'b1);
    end
    wait_idle(name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, {63'h0, in_ready}, 64'h0);
    check({name, "_blk_valid"}, {63'h0, blk_valid}, 64'h0);
    check({name, "_blk_last"}, {63'h0, blk_last}, 64'h0);
    check({name, "_blk_len"}, {60'h0, blk_len}, 64'h0);
    check({name, "_blk_data"}, blk_data, 64'h0);
    check({name, "_busy"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    logic [63:0] held;
    n_rst = 1'b0;
    start = 1'b0; start_empty = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    msg = '{8'h11, 8'h22, 8'h33};
    send_msg("three", msg);
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg("eight", msg);
    msg = {};
    send_msg("empty", msg);
    msg = {};
    for (int i = 0; i < 11; i++) msg.push_back(8'hA0 + 8'(i));
    send_msg("eleven", msg);

    // Stall in EMIT: output must hold and extra bytes must not be taken.
    rdy_auto = 1'b0;
    rdy_force = 1'b0;
    msg = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
    push_expected(msg);
    start_msg(1'b0);
    for (int i = 0; i < 8; i++) feed_byte(msg[i], 1'b0, 1'b0);
    held = blk_data;
    check("stall_first_data", held, 64'h1011_1213_1415_1617);
    in_data = 8'hEE;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_data_stable", blk_data, held);
      check("stall_in_ready", {63'h0, in_ready}, 64'h0);
      check("stall_valid", {63'h0, blk_valid}, 64'h1);
    end
    in_valid = 1'b0;
    rdy_force = 1'b1;
    feed_byte(8'h99, 1'b1, 1'b0);
    wait_idle("stall");
    rdy_auto = 1'b1;

    // Reset mid-message discards the partial block.
    start_msg(1'b0);
    for (int i = 0; i < 5; i++) feed_byte(8'hC0 + 8'(i), 1'b0, 1'b1);
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("after_reset_valid", {63'h0, blk_valid}, 64'h0);
    end
    msg = '{8'h55, 8'h66};
    send_msg("after_reset", msg);

    for (int n = 0; n < 25; n++) begin
      msg = {};
      for (int i = 0; i < $urandom_range(0, 20); i++) msg.push_back(8'($urandom));
      send_msg("random", msg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
